// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b - bin, LSB first.
// The FSM steps IDLE -> SHIFT (WIDTH cycles) -> FINISH.
// diff/bout are loaded, and done is raised, on the edge that leaves SHIFT,
// so all three are visible together for the single FINISH cycle.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             br_q, br_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    // Full-subtract cell outputs and the result with the new bit shifted in
    logic             cell_x, cell_y, cell_d, cell_br;
    logic [WIDTH-1:0] res_shift;

    // Next-state, datapath and registered-output logic
    always_comb begin
        cell_x    = a_sr_q[0];
        cell_y    = b_sr_q[0];
        cell_d    = cell_x ^ cell_y ^ br_q;
        cell_br   = (~cell_x & cell_y) | (~(cell_x ^ cell_y) & br_q);
        res_shift = {cell_d, res_q[WIDTH-1:1]};

        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        diff_d  = diff_q;
        bout_d  = bout_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    br_d    = bin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = res_shift;
                br_d   = cell_br;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    diff_d  = res_shift;
                    bout_d  = cell_br;
                    done_d  = 1'b1;
                    state_d = ST_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=8 directed cases and WIDTH=4 exhaustive.
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       rst8, start8, bin8, busy8, done8, bout8;
    logic [7:0] a8, b8, diff8;
    // WIDTH=4 instance
    logic       rst4, start4, bin4, busy4, done4, bout4;
    logic [3:0] a4, b4, diff4;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .bin(bin4),
        .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Behavioural model: an accepted start schedules the arithmetic result
    // a - b - bin to appear WIDTH+1 cycles later; rem counts busy cycles left.
    int         m8_rem = 0;
    logic [8:0] m8_pend = '0;
    logic [7:0] m8_diff = '0;
    logic       m8_bout = 1'b0, m8_done = 1'b0;

    int         m4_rem = 0;
    logic [4:0] m4_pend = '0;
    logic [3:0] m4_diff = '0;
    logic       m4_bout = 1'b0, m4_done = 1'b0;

    always @(posedge clk) begin
        if (rst8) begin
            m8_rem <= 0; m8_done <= 1'b0; m8_diff <= '0; m8_bout <= 1'b0;
        end else if (m8_rem == 0) begin
            m8_done <= 1'b0;
            if (start8) begin
                m8_rem  <= 9;
                m8_pend <= {1'b0, a8} - {1'b0, b8} - {8'd0, bin8};
            end
        end else begin
            m8_rem <= m8_rem - 1;
            if (m8_rem == 2) begin
                m8_done <= 1'b1;
                {m8_bout, m8_diff} <= m8_pend;
            end else begin
                m8_done <= 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rst4) begin
            m4_rem <= 0; m4_done <= 1'b0; m4_diff <= '0; m4_bout <= 1'b0;
        end else if (m4_rem == 0) begin
            m4_done <= 1'b0;
            if (start4) begin
                m4_rem  <= 5;
                m4_pend <= {1'b0, a4} - {1'b0, b4} - {4'd0, bin4};
            end
        end else begin
            m4_rem <= m4_rem - 1;
            if (m4_rem == 2) begin
                m4_done <= 1'b1;
                {m4_bout, m4_diff} <= m4_pend;
            end else begin
                m4_done <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m8_busy", 32'(busy8), 32'(m8_rem != 0));
            chk("m8_done", 32'(done8), 32'(m8_done));
            chk("m8_diff", 32'(diff8), 32'(m8_diff));
            chk("m8_bout", 32'(bout8), 32'(m8_bout));
            chk("m4_busy", 32'(busy4), 32'(m4_rem != 0));
            chk("m4_done", 32'(done4), 32'(m4_done));
            chk("m4_diff", 32'(diff4), 32'(m4_diff));
            chk("m4_bout", 32'(bout4), 32'(m4_bout));
        end
    end

    // From the current negedge (cycle k0 after accept) wait for done, bounded.
    task automatic wait_done8(input int k0, output int cyc, output int busyc, output bit held);
        logic [8:0] first;
        first = {bout8, diff8};
        cyc   = 0;
        busyc = 0;
        held  = 1'b1;
        for (int k = k0; k <= k0 + 20; k++) begin
            if (busy8) busyc++;
            if (done8) begin
                cyc = k;
                break;
            end
            if ({bout8, diff8} !== first) held = 1'b0;
            @(negedge clk);
        end
    endtask

    // Launch one WIDTH=8 operation; returns at the negedge of the done cycle.
    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic bi,
                       output int cyc, output int busyc, output bit held);
        @(negedge clk);
        a8 = av; b8 = bv; bin8 = bi; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        a8 = ~av; b8 = ~bv; bin8 = ~bi;
        wait_done8(1, cyc, busyc, held);
    endtask

    int cyc, busyc, dn, dcyc;
    bit held;
    logic [4:0] res4;

    initial begin
        rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
        rst4 = 1'b1; start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
        repeat (2) @(negedge clk);
        rst8 = 1'b0; rst4 = 1'b0;
        chk("reset_busy", 32'(busy8), 32'd0);
        chk("reset_done", 32'(done8), 32'd0);
        chk("reset_diff", 32'(diff8), 32'd0);
        chk("reset_bout", 32'(bout8), 32'd0);
        chk_en = 1'b1;

        // 0 - 1 wraps to all ones with borrow
        op8(8'h00, 8'h01, 1'b0, cyc, busyc, held);
        chk("wrap_latency", 32'(cyc), 32'd9);
        chk("wrap_diff", 32'(diff8), 32'hFF);
        chk("wrap_bout", 32'(bout8), 32'd1);

        // A5 - 25 - 1 = 7F, busy for 9 cycles
        op8(8'hA5, 8'h25, 1'b1, cyc, busyc, held);
        chk("a5_diff", 32'(diff8), 32'h7F);
        chk("a5_bout", 32'(bout8), 32'd0);
        chk("a5_busy_cycles", 32'(busyc), 32'd9);
        chk("a5_hold", 32'(held), 32'd1);
        @(negedge clk);
        chk("a5_busy_after", 32'(busy8), 32'd0);

        // Back-to-back: second start in the cycle after done
        op8(8'h33, 8'h11, 1'b0, cyc, busyc, held);
        chk("b2b1_diff", 32'(diff8), 32'h22);
        op8(8'h01, 8'h02, 1'b1, cyc, busyc, held);
        chk("b2b2_latency", 32'(cyc), 32'd9);
        chk("b2b2_hold", 32'(held), 32'd1);
        chk("b2b2_diff", 32'(diff8), 32'hFE);
        chk("b2b2_bout", 32'(bout8), 32'd1);

        // start pulsed 3 cycles into SHIFT is ignored
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(4, cyc, busyc, held);
        chk("ignore_latency", 32'(cyc), 32'd9);
        chk("ignore_diff", 32'(diff8), 32'h0D);
        chk("ignore_bout", 32'(bout8), 32'd0);
        @(negedge clk);
        chk("ignore_no_second", 32'(busy8), 32'd0);

        // Reset mid-SHIFT aborts: outputs cleared, no done
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_bout", 32'(bout8), 32'd0);
        dn = 0;
        for (int k = 0; k < 12; k++) begin
            if (done8) dn++;
            @(negedge clk);
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        op8(8'h05, 8'h07, 1'b1, cyc, busyc, held);
        chk("after_abort_latency", 32'(cyc), 32'd9);
        chk("after_abort_diff", 32'(diff8), 32'hFD);
        chk("after_abort_bout", 32'(bout8), 32'd1);

        // Reset wins over a simultaneous start
        @(negedge clk);
        rst8 = 1'b1; start8 = 1'b1; a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0;
        @(negedge clk);
        rst8 = 1'b0; start8 = 1'b0;
        chk("rst_over_start_busy", 32'(busy8), 32'd0);
        @(negedge clk);
        chk("rst_over_start_busy2", 32'(busy8), 32'd0);

        // Further patterns
        op8(8'hFF, 8'hFF, 1'b1, cyc, busyc, held);
        chk("ff_ff_1", 32'({bout8, diff8}), 32'h1FF);
        op8(8'h80, 8'h7F, 1'b0, cyc, busyc, held);
        chk("80_7f_0", 32'({bout8, diff8}), 32'h001);
        op8(8'hFF, 8'h00, 1'b0, cyc, busyc, held);
        chk("ff_00_0", 32'({bout8, diff8}), 32'h0FF);

        // Exhaustive WIDTH=4
        for (int unsigned ia = 0; ia < 16; ia++) begin
            for (int unsigned ib = 0; ib < 16; ib++) begin
                for (int unsigned ic = 0; ic < 2; ic++) begin
                    int e;
                    e = int'(ia) - int'(ib) - int'(ic);
                    @(negedge clk);
                    a4 = 4'(ia); b4 = 4'(ib); bin4 = ic[0]; start4 = 1'b1;
                    @(negedge clk);
                    start4 = 1'b0;
                    dn = 0; dcyc = 0; res4 = '0;
                    for (int k = 1; k <= 7; k++) begin
                        if (done4) begin
                            dn++;
                            dcyc = k;
                            res4 = {bout4, diff4};
                        end
                        if (k < 7) @(negedge clk);
                    end
                    chk("w4_result", 32'(res4), 32'(e & 31));
                    chk("w4_done_count", 32'(dn), 32'd1);
                    chk("w4_done_cycle", 32'(dcyc), 32'd5);
                end
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
